// File: rtl/bcd_display_formatter_pkg.sv
// Shared constants, FSM state type and BCD helper for the display formatter.
//   DIGITS      : number of seven-segment digits driven
//   BCD_MAX     : largest value representable in DIGITS decimal digits
//   OVF_PATTERN : value shown when the input does not fit
//   EN_RESET    : digit enable after reset (rightmost digit lit)
package bcd_display_formatter_pkg;

  localparam int          DIGITS      = 8;
  localparam logic [26:0] BCD_MAX     = 27'd99_999_999;
  localparam logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE;
  localparam logic [7:0]  EN_RESET    = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Double-dabble correction: a digit >= 5 would exceed 9 after doubling.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_display_formatter_if.sv
// Request/result bundle between a client and the display formatter.
//   start/binary/pointEn/pointPos/blankEn : request side (client -> formatter)
//   busy/done/overflow/value/enable/point : result side (formatter -> client)
interface bcd_display_formatter_if #(
  parameter int BIN_W = 27
);
  logic             start;
  logic [BIN_W-1:0] binary;
  logic             pointEn;
  logic [2:0]       pointPos;
  logic             blankEn;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [31:0]      value;
  logic [7:0]       enable;
  logic [7:0]       point;

  modport master (
    output start, binary, pointEn, pointPos, blankEn,
    input  busy, done, overflow, value, enable, point
  );

  modport slave (
    input  start, binary, pointEn, pointPos, blankEn,
    output busy, done, overflow, value, enable, point
  );
endinterface

// File: rtl/bcd_display_formatter_dabble_step.sv
// One combinational double-dabble iteration on an 8-digit BCD accumulator.
//   acc     : current packed BCD accumulator
//   bit_in  : next binary bit, MSB first
//   acc_nxt : accumulator after add-3 correction and left shift
module bcd_dabble_step
  import bcd_display_formatter_pkg::*;
(
  input  logic [31:0] acc,
  input  logic        bit_in,
  output logic [31:0] acc_nxt
);
  logic [31:0] adj;

  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = dabble_adjust(acc[4*i +: 4]);
    end
    acc_nxt = {adj[30:0], bit_in};
  end
endmodule

// File: rtl/bcd_display_formatter.sv
// Binary to packed-BCD formatter feeding an 8-digit seven-segment driver.
// Sequential double-dabble, one bit per clock; results are registered and
// only change in the FINISH cycle.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (aborts a conversion)
//   bus   : request/result bundle (slave side)
module bcd_display_formatter
  import bcd_display_formatter_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input logic                    clock,
  input logic                    reset,
  bcd_display_formatter_if.slave bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           state, state_next;
  logic [BIN_W-1:0] bin_sr;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc, acc_next;
  logic             pe_lat, be_lat, ovf_lat;
  logic [2:0]       pp_lat;
  logic [26:0]      bin_ext;

  logic [31:0]      value_r;
  logic [7:0]       enable_r, point_r, fin_enable, fin_point;
  logic             ovf_r, done_r;
  logic [2:0]       hi_digit, min_digit, lim;

  bcd_dabble_step u_step (
    .acc     (acc),
    .bit_in  (bin_sr[BIN_W-1]),
    .acc_nxt (acc_next)
  );

  always_comb begin
    bin_ext = '0;
    bin_ext[BIN_W-1:0] = bus.binary;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Blanking limit: highest nonzero digit, extended up to the point position.
  always_comb begin
    hi_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] != 4'd0) hi_digit = 3'(i);
    end
    min_digit = pe_lat ? pp_lat : 3'd0;
    lim       = (hi_digit > min_digit) ? hi_digit : min_digit;
    fin_point = pe_lat ? (8'b1 << pp_lat) : 8'h00;
    fin_enable = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      fin_enable[i] = !be_lat || (3'(i) <= lim);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      bin_sr   <= '0;
      cnt      <= '0;
      acc      <= '0;
      pe_lat   <= 1'b0;
      be_lat   <= 1'b0;
      pp_lat   <= '0;
      ovf_lat  <= 1'b0;
      value_r  <= '0;
      enable_r <= EN_RESET;
      point_r  <= '0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= (state == FINISH);
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr  <= bus.binary;
            pe_lat  <= bus.pointEn;
            pp_lat  <= bus.pointPos;
            be_lat  <= bus.blankEn;
            // Range check done at latch time so the shift register can be consumed.
            ovf_lat <= (bin_ext > BCD_MAX);
            acc     <= '0;
            cnt     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          acc    <= acc_next;
          bin_sr <= bin_sr << 1;
          cnt    <= cnt - 1'b1;
        end
        FINISH: begin
          ovf_r <= ovf_lat;
          if (ovf_lat) begin
            value_r  <= OVF_PATTERN;
            enable_r <= 8'hFF;
            point_r  <= 8'h00;
          end else begin
            value_r  <= acc;
            enable_r <= fin_enable;
            point_r  <= fin_point;
          end
        end
        default: ;
      endcase
    end
  end

  // busy stays high through the done cycle so it falls together with done.
  assign bus.busy     = (state != IDLE) || done_r;
  assign bus.done     = done_r;
  assign bus.overflow = ovf_r;
  assign bus.value    = value_r;
  assign bus.enable   = enable_r;
  assign bus.point    = point_r;
endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed, table-driven bench for bcd_display_formatter (BIN_W = 27).
module tb_bcd_display_formatter;
  localparam int BIN_W = 27;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bcd_display_formatter_if #(.BIN_W(BIN_W)) bus ();
  bcd_display_formatter #(.BIN_W(BIN_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [26:0] bin;
    logic        pe;
    logic [2:0]  pp;
    logic        be;
    logic [31:0] v;
    logic [7:0]  en;
    logic [7:0]  pt;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one edge, then scramble the inputs to prove they are shadowed.
  task automatic start_conv(input logic [26:0] b, input logic pe, input logic [2:0] pp, input logic be);
    bus.binary   = b;
    bus.pointEn  = pe;
    bus.pointPos = pp;
    bus.blankEn  = be;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.binary   = 27'($urandom);
    bus.pointEn  = ~pe;
    bus.pointPos = 3'($urandom);
    bus.blankEn  = ~be;
  endtask

  task automatic wait_done(output int cyc, output logic busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 60) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t t);
    int   cyc;
    logic bok;
    start_conv(t.bin, t.pe, t.pp, t.be);
    wait_done(cyc, bok);
    check({tag, "_latency"}, 32'(cyc), 32'd28);
    check({tag, "_busy_during"}, 32'(bok), 32'd1);
    check({tag, "_value"}, bus.value, t.v);
    check({tag, "_enable"}, 32'(bus.enable), 32'(t.en));
    check({tag, "_point"}, 32'(bus.point), 32'(t.pt));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(t.ovf));
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    repeat (3) tick();
    check({tag, "_value_held"}, bus.value, t.v);
  endtask

  initial begin
    int   cyc, pulses;
    logic bok;
    logic [31:0] seen;

    vecs[0]  = '{27'd12_345_678,  1'b0, 3'd0, 1'b1, 32'h1234_5678, 8'hFF, 8'h00, 1'b0};
    vecs[1]  = '{27'd42,          1'b1, 3'd3, 1'b1, 32'h0000_0042, 8'h0F, 8'h08, 1'b0};
    vecs[2]  = '{27'd42,          1'b1, 3'd3, 1'b0, 32'h0000_0042, 8'hFF, 8'h08, 1'b0};
    vecs[3]  = '{27'd0,           1'b0, 3'd0, 1'b1, 32'h0000_0000, 8'h01, 8'h00, 1'b0};
    vecs[4]  = '{27'd99_999_999,  1'b0, 3'd0, 1'b1, 32'h9999_9999, 8'hFF, 8'h00, 1'b0};
    vecs[5]  = '{27'd100_000_000, 1'b1, 3'd2, 1'b1, 32'hEEEE_EEEE, 8'hFF, 8'h00, 1'b1};
    vecs[6]  = '{27'd7,           1'b0, 3'd0, 1'b1, 32'h0000_0007, 8'h01, 8'h00, 1'b0};
    vecs[7]  = '{27'd1000,        1'b1, 3'd7, 1'b1, 32'h0000_1000, 8'hFF, 8'h80, 1'b0};
    vecs[8]  = '{27'd5000,        1'b1, 3'd1, 1'b1, 32'h0000_5000, 8'h0F, 8'h02, 1'b0};
    vecs[9]  = '{27'd1000,        1'b0, 3'd5, 1'b1, 32'h0000_1000, 8'h0F, 8'h00, 1'b0};
    vecs[10] = '{27'd0,           1'b1, 3'd0, 1'b1, 32'h0000_0000, 8'h01, 8'h01, 1'b0};
    vecs[11] = '{27'd134_217_727, 1'b0, 3'd0, 1'b0, 32'hEEEE_EEEE, 8'hFF, 8'h00, 1'b1};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.binary = '0;
    bus.pointEn = 1'b0;
    bus.pointPos = '0;
    bus.blankEn = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_value", bus.value, 32'h0);
    check("rst_enable", 32'(bus.enable), 32'h01);
    check("rst_point", 32'(bus.point), 32'h00);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);

    for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // start during a conversion is ignored and not queued
    start_conv(27'd5, 1'b0, 3'd0, 1'b1);
    repeat (9) tick();
    bus.binary = 27'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    seen = '0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done === 1'b1) begin
        pulses++;
        seen = bus.value;
      end
      tick();
    end
    check("ignore_start_pulses", 32'(pulses), 32'd1);
    check("ignore_start_value", seen, 32'h5);
    check("ignore_start_enable", 32'(bus.enable), 32'h01);

    // reset mid-conversion after a result with nonreset outputs
    run_vec("pre_rst", vecs[5]);
    start_conv(27'd123, 1'b1, 3'd4, 1'b1);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_value", bus.value, 32'h0);
    check("abort_enable", 32'(bus.enable), 32'h01);
    check("abort_point", 32'(bus.point), 32'h00);
    check("abort_overflow", 32'(bus.overflow), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      tick();
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_vec("post_rst", '{27'd123, 1'b0, 3'd0, 1'b1, 32'h0000_0123, 8'h07, 8'h00, 1'b0});

    // back-to-back: new start accepted in the done cycle
    start_conv(27'd2, 1'b0, 3'd0, 1'b1);
    wait_done(cyc, bok);
    check("b2b_first_value", bus.value, 32'h2);
    start_conv(27'd1, 1'b0, 3'd0, 1'b1);
    wait_done(cyc, bok);
    check("b2b_spacing", 32'(cyc + 1), 32'd29);
    check("b2b_second_value", bus.value, 32'h1);
    check("b2b_second_enable", 32'(bus.enable), 32'h01);
    check("b2b_busy_during", 32'(bok), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_display_formatter.md
Name: bcd_display_formatter

Overview:
- Upstream feeder for the 8-digit multiplexed seven-segment driver.
- Accepts an unsigned binary number and converts it to packed BCD with a sequential double-dabble, one bit per cycle.
- Produces the driver's three inputs: value[31:0] (8 BCD nibbles), enable[7:0] (leading-zero blanking) and point[7:0] (one-hot decimal point).
- Outputs are registered and held stable between conversions, so the display never flickers mid-conversion.

Parameters:
- BIN_W, 27, width of binary input; legal range 1..27.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request conversion; sampled only in IDLE.
- binary  in  BIN_W  unsigned value to display.
- pointEn  in  1  1 = light a decimal point.
- pointPos  in  3  digit index of the decimal point (0 = rightmost).
- blankEn  in  1  1 = blank leading zeros.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; outputs just updated.
- overflow  out  1  last result exceeded 99_999_999.
- value  out  32  packed BCD; digit i is value[4i+3:4i].
- enable  out  8  per-digit enable, 1 = lit.
- point  out  8  one-hot decimal point, 1 = lit.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. It overrides everything, including a conversion in progress, which is aborted with no done pulse.
- Reset values: state IDLE, busy 0, done 0, overflow 0, value 32'h0, enable 8'h01, point 8'h00.
- FSM has three states: IDLE, SHIFT, FINISH.
- IDLE:
  - On start=1, latch binary, pointEn, pointPos and blankEn into shadow registers.
  - Clear the 32-bit BCD accumulator and load the bit counter with BIN_W.
  - Go to SHIFT. busy=1 from the next cycle.
- SHIFT, per cycle:
  - Add 3 to every accumulator nibble that is >=5.
  - Shift left by one, inserting the MSB of the binary shift register.
  - Shift the binary register left and decrement the counter.
  - Exactly BIN_W SHIFT cycles, then go to FINISH.
- FINISH (one cycle): register value, enable, point and overflow; set done=1 for the following cycle; return to IDLE. busy falls with done.
- Latency: start sampled at edge k; new outputs and done=1 are visible after edge k+BIN_W+1. That is 28 cycles for BIN_W=27.
- Throughput: start sampled in the cycle where done=1 is accepted (state is IDLE), so back-to-back conversions run every BIN_W+2 cycles.
- start while busy=1 is ignored; it is not queued.
- Input changes during a conversion have no effect, because shadow registers are used.
- Overflow:
  - Condition: latched binary > 27'd99_999_999 (possible only when BIN_W=27).
  - Result: value=32'hEEEE_EEEE, enable=8'hFF, point=8'h00, overflow=1.
  - Any non-overflow result clears overflow.
- point = pointEn ? (8'b1 << pointPos) : 8'h00.
- enable, for non-overflow results:
  - If blankEn=0: 8'hFF.
  - Otherwise let h = index of the highest nonzero digit (0 if all digits are zero), and m = pointEn ? pointPos : 0.
  - enable[i] = (i <= max(h, m)).
  - Consequences: digit 0 is always lit, and digits at or below the point are never blanked.
- All outputs are held unchanged between FINISH updates.

Decomposition:
- Shared package:
  - DIGITS=8.
  - BCD_MAX=27'd99_999_999.
  - OVF_PATTERN=32'hEEEE_EEEE.
  - Reset enable constant 8'h01.
  - FSM state encodings (2-bit IDLE/SHIFT/FINISH).
- One sub-module: bcd_dabble_step, a purely combinational block.
  - Inputs: 32-bit accumulator and serial input bit.
  - Output: the next accumulator after the add-3 correction and shift.
  - It keeps the FSM file focused on control, and the blanking logic stays in the top level.

Test Plan:
1. binary=12_345_678, blankEn=1, pointEn=0, start pulsed at edge k -> at k+28: value=32'h12345678, enable=8'hFF, point=8'h00, overflow=0. done high for exactly 1 cycle; busy high for cycles k+1..k+28 and low at k+29.
2. binary=42, blankEn=1, pointEn=1, pointPos=3 -> value=32'h00000042, enable=8'h0F, point=8'h08. Then repeat with blankEn=0 -> enable=8'hFF.
3. binary=0, blankEn=1, pointEn=0 -> value=32'h0, enable=8'h01, point=8'h00.
4. Boundary pair:
   - binary=99_999_999 -> value=32'h99999999, overflow=0.
   - Next, binary=100_000_000 -> value=32'hEEEEEEEE, enable=8'hFF, point=8'h00, overflow=1.
   - Next, binary=7 -> overflow back to 0.
5. Mid-conversion events:
   - Start with binary=5. At cycle 10 change binary to 9 and pulse start -> result value=32'h5, with only one done pulse.
   - New conversion with binary=123; assert reset at cycle 15 -> all outputs return to reset values, busy=0, no done pulse. The following start completes normally.
6. Back-to-back: assert start in the done cycle with binary=1 after binary=2 -> second done arrives exactly 29 cycles after the first, with value=32'h1 and enable=8'h01.
